echo_mixer: RTL and testbench

- Downstream consumer of the signal-delay stage. Mixes the live mic sample with the delayed sample to produce an echo.
- Echo level is set by a gain that ramps smoothly toward its target, so enabling or changing the echo does not cause audible clicks.
- Samples are unsigned offset-binary; midscale 2^(DATA_WIDTH-1) represents silence.
- Output feeds the DAC/scope sink.

---
 rtl/echo_mixer_if.sv | 21 ++
 rtl/echo_mixer.sv | 143 ++++++++++++++
 tb/tb_echo_mixer.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/echo_mixer_if.sv
// Sample-pair input and mixed-sample output bundle for echo_mixer.
// slave = mixer side, master = producer/consumer side.
interface echo_mixer_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  in_valid;
  logic [DATA_WIDTH-1:0] mic_signal;
  logic [DATA_WIDTH-1:0] delayed_signal;
  logic                  out_valid;
  logic [DATA_WIDTH-1:0] mix_signal;

  modport master (
    output in_valid, mic_signal, delayed_signal,
    input  out_valid, mix_signal
  );

  modport slave (
    input  in_valid, mic_signal, delayed_signal,
    output out_valid, mix_signal
  );
endinterface

// File: rtl/echo_mixer.sv
// Echo mixer: mic + ramped gain * (delayed - midscale), saturated; ECHO_MIXER_CLIP_EN adds clip flags.
// Latency: 2 cycles from in_valid to out_valid.
// Backpressure: none; a sample pair may be accepted every cycle.
module echo_mixer #(
  parameter int DATA_WIDTH = 8,
  parameter int GAIN_WIDTH = 4,
  parameter int RAMP_DIV   = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  echo_mixer_if.slave           io,
  input  logic                  en,
  input  logic [GAIN_WIDTH-1:0] target_gain,
  output logic [GAIN_WIDTH-1:0] cur_gain,
  output logic                  busy
`ifdef ECHO_MIXER_CLIP_EN
  ,
  output logic                  clip,
  output logic                  clip_sticky
`endif
);

  localparam int PW = DATA_WIDTH + GAIN_WIDTH + 1;
  localparam int SW = DATA_WIDTH + 2;
  localparam int CW = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
  localparam logic [CW-1:0]         CNT_LAST = CW'(RAMP_DIV - 1);
  localparam logic [DATA_WIDTH:0]   MID      = (DATA_WIDTH+1)'(1) << (DATA_WIDTH - 1);
  localparam logic [DATA_WIDTH-1:0] MID_OUT  = DATA_WIDTH'(1) << (DATA_WIDTH - 1);
  localparam logic signed [SW-1:0]  SMAX     = SW'((1 << DATA_WIDTH) - 1);

  typedef enum logic [1:0] {IDLE, RAMP_UP, STEADY, RAMP_DOWN} state_t;

  typedef struct packed {
    logic                  vld;
    logic [DATA_WIDTH-1:0] mic;
    logic [PW-1:0]         p;
  } s1_t;

  state_t                state, state_nxt;
  logic [CW-1:0]         cnt, cnt_nxt;
  logic [GAIN_WIDTH-1:0] gain_nxt, goal;
  logic                  ramping, enter_ramp, ramp_tick;

  s1_t                      s1;
  logic signed [DATA_WIDTH:0] c;
  logic signed [PW-1:0]     p;
  logic signed [SW-1:0]     p_sh, s;
  logic                     sat_lo, sat_hi;
  logic [DATA_WIDTH-1:0]    mix_nxt;

  always_comb begin
    goal      = en ? target_gain : '0;
    state_nxt = state;
    case (state)
      IDLE:      if (goal != '0) state_nxt = RAMP_UP;
      RAMP_UP:   if (cur_gain == goal) state_nxt = STEADY;
                 else if (goal < cur_gain) state_nxt = RAMP_DOWN;
      STEADY:    if (goal > cur_gain) state_nxt = RAMP_UP;
                 else if (goal < cur_gain) state_nxt = RAMP_DOWN;
      RAMP_DOWN: if (cur_gain == goal) state_nxt = (goal == '0) ? IDLE : STEADY;
                 else if (goal > cur_gain) state_nxt = RAMP_UP;
      default:   state_nxt = IDLE;
    endcase

    ramping    = (state == RAMP_UP) || (state == RAMP_DOWN);
    enter_ramp = (state_nxt != state) && ((state_nxt == RAMP_UP) || (state_nxt == RAMP_DOWN));
    ramp_tick  = ramping && io.in_valid && (cnt == CNT_LAST);

    cnt_nxt = cnt;
    if (enter_ramp)
      cnt_nxt = '0;
    else if (ramping && io.in_valid)
      cnt_nxt = (cnt == CNT_LAST) ? '0 : cnt + CW'(1);

    // Step only while still short of the goal, so a redirect never overshoots.
    gain_nxt = cur_gain;
    if (ramp_tick && (state == RAMP_UP) && (goal > cur_gain))
      gain_nxt = cur_gain + GAIN_WIDTH'(1);
    else if (ramp_tick && (state == RAMP_DOWN) && (goal < cur_gain))
      gain_nxt = cur_gain - GAIN_WIDTH'(1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      cnt      <= '0;
      cur_gain <= '0;
      busy     <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      cur_gain <= gain_nxt;
      busy     <= (state_nxt == RAMP_UP) || (state_nxt == RAMP_DOWN);
    end
  end

  assign c = $signed({1'b0, io.delayed_signal} - MID);
  assign p = PW'(c) * PW'($signed({1'b0, cur_gain}));

  assign p_sh   = SW'($signed(s1.p) >>> GAIN_WIDTH);
  assign s      = $signed(SW'({1'b0, s1.mic})) + p_sh;
  assign sat_lo = s < 0;
  assign sat_hi = s > SMAX;

  always_comb begin
    mix_nxt = s[DATA_WIDTH-1:0];
    if (sat_lo)
      mix_nxt = '0;
    else if (sat_hi)
      mix_nxt = '1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1            <= '0;
      io.out_valid  <= 1'b0;
      io.mix_signal <= MID_OUT;
    end else begin
      s1.vld <= io.in_valid;
      if (io.in_valid) begin
        s1.mic <= io.mic_signal;
        s1.p   <= p;
      end
      io.out_valid <= s1.vld;
      if (s1.vld)
        io.mix_signal <= mix_nxt;
    end
  end

`ifdef ECHO_MIXER_CLIP_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      clip        <= 1'b0;
      clip_sticky <= 1'b0;
    end else begin
      clip <= s1.vld && (sat_lo || sat_hi);
      if (s1.vld && (sat_lo || sat_hi))
        clip_sticky <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_echo_mixer.sv
// Bench for echo_mixer: reference model of gain trajectory and mix arithmetic, plus directed literal checks.
module tb_echo_mixer;
  localparam int DW = 8, GW = 4, RD = 16;
  localparam int MID = 128, MAXV = 255;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          en = 1'b0;
  logic [GW-1:0] target_gain = '0;
  logic [GW-1:0] cur_gain;
  logic          busy;
`ifdef ECHO_MIXER_CLIP_EN
  logic          clip, clip_sticky;
`endif

  echo_mixer_if #(.DATA_WIDTH(DW)) io();

  echo_mixer #(.DATA_WIDTH(DW), .GAIN_WIDTH(GW), .RAMP_DIV(RD)) dut (
    .clk(clk), .reset(reset), .io(io), .en(en), .target_gain(target_gain),
    .cur_gain(cur_gain), .busy(busy)
`ifdef ECHO_MIXER_CLIP_EN
    , .clip(clip), .clip_sticky(clip_sticky)
`endif
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  function automatic int fdiv(input int a, input int b);
    int q;
    q = a / b;
    if ((a % b != 0) && (a < 0)) q = q - 1;
    return q;
  endfunction

  // Model: gain phase 0=idle 1=rising 2=holding 3=falling; samples count toward a step only while moving.
  int m_gain = 0, m_phase = 0, m_cnt = 0, m_goal = 0, m_s = 0;
  int m_mix1 = MID, m_mix = MID;
  bit m_v1 = 0, m_clip1 = 0, m_ov = 0, m_clip = 0, m_sticky = 0, m_busy = 0;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_gain = 0; m_phase = 0; m_cnt = 0; m_v1 = 0; m_ov = 0;
      m_mix = MID; m_clip = 0; m_sticky = 0; m_busy = 0;
    end else begin
      m_goal = en ? int'(target_gain) : 0;
      m_ov = m_v1;
      m_clip = 0;
      if (m_v1) begin
        m_mix = m_mix1;
        m_clip = m_clip1;
        if (m_clip1) m_sticky = 1;
      end
      m_v1 = io.in_valid;
      if (io.in_valid) begin
        m_s = int'(io.mic_signal) + fdiv((int'(io.delayed_signal) - MID) * m_gain, 1 << GW);
        m_clip1 = (m_s < 0) || (m_s > MAXV);
        m_mix1 = (m_s < 0) ? 0 : ((m_s > MAXV) ? MAXV : m_s);
      end
      if (m_phase == 0) begin
        if (m_goal > 0) begin m_phase = 1; m_cnt = 0; end
      end else if (m_phase == 2) begin
        if (m_goal != m_gain) begin m_phase = (m_goal > m_gain) ? 1 : 3; m_cnt = 0; end
      end else if (m_gain == m_goal) begin
        m_phase = (m_phase == 3 && m_goal == 0) ? 0 : 2;
      end else if ((m_phase == 1) != (m_goal > m_gain)) begin
        m_phase = (m_goal > m_gain) ? 1 : 3; m_cnt = 0;
      end else if (io.in_valid) begin
        m_cnt++;
        if (m_cnt == RD) begin
          m_cnt = 0;
          m_gain += (m_phase == 1) ? 1 : -1;
        end
      end
      m_busy = (m_phase == 1) || (m_phase == 3);
    end
  end

  always @(negedge clk) begin
    chk("out_valid", io.out_valid, m_ov);
    chk("mix_signal", io.mix_signal, m_mix);
    chk("cur_gain", cur_gain, m_gain);
    chk("busy", busy, m_busy);
`ifdef ECHO_MIXER_CLIP_EN
    chk("clip", clip, m_clip);
    chk("clip_sticky", clip_sticky, m_sticky);
`endif
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_one(input int mic, input int dl, input int lit, input string name);
    bit got;
    io.in_valid = 1'b0;
    repeat (2) tick();
    io.in_valid = 1'b1;
    io.mic_signal = DW'(mic);
    io.delayed_signal = DW'(dl);
    tick();
    io.in_valid = 1'b0;
    got = 0;
    for (int i = 0; i < 6 && !got; i++) begin
      @(negedge clk);
      if (io.out_valid) begin
        got = 1;
        chk(name, io.mix_signal, lit);
      end
    end
    chk({name, "_out_valid_seen"}, got, 1);
  endtask

  task automatic wait_idle(input int budget, input string name);
    bit done;
    done = 0;
    io.in_valid = 1'b1;
    for (int i = 0; i < budget && !done; i++) begin
      tick();
      if (!busy) done = 1;
    end
    chk({name, "_settled"}, done, 1);
  endtask

  initial begin
    bit found;
    io.in_valid = 1'b0;
    io.mic_signal = '0;
    io.delayed_signal = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", io.out_valid, 0);
    chk("rst_mix", io.mix_signal, 128);
    chk("rst_gain", cur_gain, 0);
    chk("rst_busy", busy, 0);
    reset = 1'b1;
    tick();

    send_one(100, 200, 100, "passthrough_mix");
    chk("pass_gain", cur_gain, 0);
    chk("pass_busy", busy, 0);
`ifdef ECHO_MIXER_CLIP_EN
    chk("pass_sticky", clip_sticky, 0);
`endif

    en = 1'b1;
    target_gain = 4'd8;
    io.mic_signal = 8'd100;
    io.delayed_signal = 8'd200;
    io.in_valid = 1'b1;
    tick();
    chk("ramp_busy", busy, 1);
    repeat (16) tick();
    chk("ramp_gain_after_16", cur_gain, 1);
    repeat (112) tick();
    chk("ramp_gain_after_128", cur_gain, 8);
    chk("ramp_busy_at_8", busy, 1);
    tick();
    chk("steady_busy", busy, 0);
    send_one(100, 200, 136, "gain8_mix");

    target_gain = 4'd15;
    wait_idle(300, "ramp_to_15");
    chk("gain_15", cur_gain, 15);
    repeat (20) tick();
    chk("gain_max_hold", cur_gain, 15);
    send_one(250, 255, 255, "sat_high_mix");
    send_one(10, 0, 0, "sat_low_mix");
`ifdef ECHO_MIXER_CLIP_EN
    chk("sat_sticky", clip_sticky, 1);
`endif

    target_gain = 4'd1;
    wait_idle(400, "ramp_to_1");
    chk("gain_1", cur_gain, 1);
    send_one(50, 127, 49, "floor_mix");

    target_gain = 4'd10;
    io.in_valid = 1'b1;
    found = 0;
    for (int i = 0; i < 200 && !found; i++) begin
      tick();
      if (cur_gain == 4'd5) found = 1;
    end
    chk("reach_gain_5", found, 1);
    target_gain = 4'd3;
    tick();
    chk("redirect_busy", busy, 1);
    chk("redirect_gain", cur_gain, 5);
    found = 0;
    for (int i = 0; i < 300 && !found; i++) begin
      io.in_valid = (i % 3 != 0);
      tick();
      if (!busy) found = 1;
    end
    chk("down_settled", found, 1);
    chk("gain_3", cur_gain, 3);

    en = 1'b0;
    io.in_valid = 1'b0;
    repeat (40) tick();
    chk("freeze_gain", cur_gain, 3);
    chk("freeze_busy", busy, 1);
    wait_idle(200, "ramp_to_0");
    chk("gain_0", cur_gain, 0);
    chk("idle_busy", busy, 0);

    en = 1'b1;
    target_gain = 4'd8;
    io.in_valid = 1'b1;
    repeat (20) tick();
    chk("pre_reset_gain", cur_gain, 1);
    #2 reset = 1'b0;
    #1;
    chk("midrst_out_valid", io.out_valid, 0);
    chk("midrst_mix", io.mix_signal, 128);
    chk("midrst_gain", cur_gain, 0);
    chk("midrst_busy", busy, 0);
    @(posedge clk);
    #1;
    io.in_valid = 1'b0;
    en = 1'b0;
    reset = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("flushed_no_out", io.out_valid, 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
